// File: rtl/ulpi_tx_arbiter_if.sv
// Bundle of the two requester streams, the shared ULPI TX stream and the arbiter status.
// A beat moves on any stream only in a cycle where its tvalid and tready are both high;
// a source holds tvalid/tdata/tlast stable until that beat is accepted, and tready may
// be low at any time.
interface ulpi_tx_arbiter_if;
  logic       rx_active;
  logic [7:0] pkt_tdata;
  logic       pkt_tvalid;
  logic       pkt_tlast;
  logic       pkt_tready;
  logic       pkt_abort;
  logic [7:0] reg_tdata;
  logic       reg_tvalid;
  logic       reg_tlast;
  logic       reg_tready;
  logic       reg_abort;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tlast;
  logic       tx_tready;
  logic       busy;
  logic [1:0] dbg_state;  // 0 idle, 1 pkt owner, 2 reg owner, 3 gap

  modport master (
    input  rx_active,
    input  pkt_tdata, pkt_tvalid, pkt_tlast,
    input  reg_tdata, reg_tvalid, reg_tlast,
    input  tx_tready,
    output pkt_tready, pkt_abort,
    output reg_tready, reg_abort,
    output tx_tdata, tx_tvalid, tx_tlast,
    output busy, dbg_state
  );

  modport slave (
    output rx_active,
    output pkt_tdata, pkt_tvalid, pkt_tlast,
    output reg_tdata, reg_tvalid, reg_tlast,
    output tx_tready,
    input  pkt_tready, pkt_abort,
    input  reg_tready, reg_abort,
    input  tx_tdata, tx_tvalid, tx_tlast,
    input  busy, dbg_state
  );
endinterface

// File: rtl/ulpi_tx_arbiter.sv
// Round-robin, whole-transfer arbiter sharing the ULPI TX stream between the packet
// transmitter and the PHY register sequencer, with RX/stall abort and an inter-transfer gap.
module ulpi_tx_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic               clk,
  input  logic               rst,
  ulpi_tx_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_REG  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int               TO_LIM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LIM   = TO_LIM_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] GAP_LIM  = GAP_CYCLES[CNT_W-1:0];
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);

  state_t           state;
  logic             last_reg;   // 1 when reg owned the last completed transfer
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             pkt_abort_q;
  logic             reg_abort_q;

  logic in_pkt;
  logic in_reg;
  logic own_valid;
  logic hs;
  logic stall_to;

  always_comb begin
    in_pkt        = (state == S_PKT);
    in_reg        = (state == S_REG);
    own_valid     = 1'b0;
    bus.tx_tdata  = 8'h00;
    bus.tx_tlast  = 1'b0;
    if (in_pkt) begin
      own_valid    = bus.pkt_tvalid;
      bus.tx_tdata = bus.pkt_tdata;
      bus.tx_tlast = bus.pkt_tlast;
    end else if (in_reg) begin
      own_valid    = bus.reg_tvalid;
      bus.tx_tdata = bus.reg_tdata;
      bus.tx_tlast = bus.reg_tlast;
    end
    // RX turnaround blocks both directions of the owner's handshake in the same cycle.
    bus.tx_tvalid  = own_valid & ~bus.rx_active;
    bus.pkt_tready = in_pkt & bus.tx_tready & ~bus.rx_active;
    bus.reg_tready = in_reg & bus.tx_tready & ~bus.rx_active;
    hs             = bus.tx_tvalid & bus.tx_tready;
    stall_to       = TO_EN && !hs && (cnt >= TO_LIM);
  end

  assign bus.busy      = busy_q;
  assign bus.pkt_abort = pkt_abort_q;
  assign bus.reg_abort = reg_abort_q;
  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last_reg    <= 1'b0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      pkt_abort_q <= 1'b0;
      reg_abort_q <= 1'b0;
    end else begin
      pkt_abort_q <= 1'b0;
      reg_abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.rx_active) begin
            // On a tie the requester that did not finish last wins.
            if (bus.pkt_tvalid && (!bus.reg_tvalid || last_reg)) begin
              state  <= S_PKT;
              busy_q <= 1'b1;
              cnt    <= '0;
            end else if (bus.reg_tvalid) begin
              state  <= S_REG;
              busy_q <= 1'b1;
              cnt    <= '0;
            end
          end
        end
        S_PKT, S_REG: begin
          if (bus.rx_active || stall_to) begin
            state <= S_GAP;
            cnt   <= '0;
            if (in_pkt) pkt_abort_q <= 1'b1;
            else        reg_abort_q <= 1'b1;
          end else if (hs && bus.tx_tlast) begin
            state    <= S_GAP;
            cnt      <= '0;
            last_reg <= in_reg;
          end else if (hs) begin
            cnt <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if ((cnt >= GAP_LIM) && !bus.rx_active) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// Directed bench for ulpi_tx_arbiter (GAP_CYCLES=2, TIMEOUT_CYCLES=8): grant latency,
// round-robin ties, RX abort, stall timeout, transfer locking and async reset.
module tb_ulpi_tx_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_REG  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   n_pkt_ab;
  int   n_reg_ab;
  logic [8:0] exp_q[$];

  ulpi_tx_arbiter_if u_if ();

  ulpi_tx_arbiter #(
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (11)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input bit v, input logic [7:0] d, input bit l);
    u_if.pkt_tvalid = v;
    u_if.pkt_tdata  = d;
    u_if.pkt_tlast  = l;
  endtask

  task automatic drive_reg(input bit v, input logic [7:0] d, input bit l);
    u_if.reg_tvalid = v;
    u_if.reg_tdata  = d;
    u_if.reg_tlast  = l;
  endtask

  // Presents one beat on a requester and holds it until accepted.
  task automatic send_beat(input bit is_reg, input logic [7:0] d, input bit last);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    exp_q.push_back({last, d});
    if (is_reg) drive_reg(1'b1, d, last);
    else        drive_pkt(1'b1, d, last);
    while (!done && n < 100) begin
      #1;
      done = is_reg ? u_if.reg_tready : u_if.pkt_tready;
      cyc();
      n++;
    end
    check(is_reg ? "reg_beat_done" : "pkt_beat_done", {31'd0, done}, 32'd1);
    if (is_reg) drive_reg(1'b0, 8'h00, 1'b0);
    else        drive_pkt(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n;
    n = 0;
    while (u_if.dbg_state != s && n < 100) begin
      cyc();
      n++;
    end
    check(tag, {30'd0, u_if.dbg_state}, {30'd0, s});
  endtask

  // scoreboard: every TX beat must match the head of exp_q
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (u_if.pkt_abort) n_pkt_ab++;
      if (u_if.reg_abort) n_reg_ab++;
      check("abort_excl", {31'd0, u_if.pkt_abort & u_if.reg_abort}, 32'd0);
      if (u_if.tx_tvalid && u_if.tx_tready) begin
        check("hs_in_rx", {31'd0, u_if.rx_active}, 32'd0);
        if (exp_q.size() == 0) begin
          check("beat_extra", {23'd0, u_if.tx_tlast, u_if.tx_tdata}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("beat", {23'd0, u_if.tx_tlast, u_if.tx_tdata}, {23'd0, e});
        end
      end
    end
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    n_pkt_ab = 0;
    n_reg_ab = 0;
    rst = 1'b1;
    u_if.rx_active = 1'b0;
    u_if.tx_tready = 1'b1;
    drive_pkt(1'b0, 8'h00, 1'b0);
    drive_reg(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_aborts", {30'd0, u_if.pkt_abort, u_if.reg_abort}, 32'd0);
    check("rst_valid_ready", {29'd0, u_if.tx_tvalid, u_if.pkt_tready, u_if.reg_tready}, 32'd0);
    rst = 1'b0;

    // single reg write: beats on cycles 1 and 2 after reg_tvalid, then 3 gap cycles
    exp_q.push_back({1'b0, 8'h84});
    exp_q.push_back({1'b1, 8'h55});
    drive_reg(1'b1, 8'h84, 1'b0);
    #1;
    check("grant_cost", {31'd0, u_if.tx_tvalid}, 32'd0);
    cyc();
    check("s1_grant", {30'd0, u_if.dbg_state}, {30'd0, ST_REG});
    check("s1_busy", {31'd0, u_if.busy}, 32'd1);
    #1;
    check("s1_b0", {23'd0, u_if.tx_tvalid, u_if.tx_tdata}, 32'h184);
    cyc();
    drive_reg(1'b1, 8'h55, 1'b1);
    #1;
    check("s1_b1", {22'd0, u_if.tx_tvalid, u_if.tx_tlast, u_if.tx_tdata}, 32'h355);
    cyc();
    drive_reg(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("s1_gap", {30'd0, u_if.dbg_state}, {30'd0, ST_GAP});
      cyc();
    end
    check("s1_idle", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
    check("s1_busy_end", {31'd0, u_if.busy}, 32'd0);

    // tie from reset: reg first, then pkt, then alternation
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive_pkt(1'b1, 8'hA1, 1'b1);
    drive_reg(1'b1, 8'hB1, 1'b1);
    cyc();
    check("tie1_reg", {30'd0, u_if.dbg_state}, {30'd0, ST_REG});
    send_beat(1'b1, 8'hB1, 1'b1);
    wait_state(ST_PKT, "tie2_pkt");
    send_beat(1'b0, 8'hA1, 1'b1);
    drive_pkt(1'b1, 8'hA2, 1'b1);
    drive_reg(1'b1, 8'hB2, 1'b1);
    wait_state(ST_IDLE, "alt_idle1");
    cyc();
    check("alt_reg", {30'd0, u_if.dbg_state}, {30'd0, ST_REG});
    send_beat(1'b1, 8'hB2, 1'b1);
    drive_reg(1'b1, 8'hB3, 1'b1);
    wait_state(ST_IDLE, "alt_idle2");
    cyc();
    check("alt_pkt", {30'd0, u_if.dbg_state}, {30'd0, ST_PKT});
    send_beat(1'b0, 8'hA2, 1'b1);
    send_beat(1'b1, 8'hB3, 1'b1);
    wait_state(ST_IDLE, "alt_done");

    // RX interrupt after beat 2 of a 4-byte packet, rx high for 5 cycles
    send_beat(1'b0, 8'hC0, 1'b0);
    send_beat(1'b0, 8'hC1, 1'b0);
    u_if.rx_active = 1'b1;
    drive_pkt(1'b1, 8'hC2, 1'b0);
    #1;
    check("rx_gate", {30'd0, u_if.tx_tvalid, u_if.pkt_tready}, 32'd0);
    cyc();
    check("rx_abort", {30'd0, u_if.pkt_abort, u_if.reg_abort}, 32'd2);
    check("rx_gap", {30'd0, u_if.dbg_state}, {30'd0, ST_GAP});
    drive_pkt(1'b1, 8'hC0, 1'b0);
    cyc();
    check("rx_abort_1cyc", {31'd0, u_if.pkt_abort}, 32'd0);
    repeat (3) cyc();
    check("rx_gap_hold", {30'd0, u_if.dbg_state}, {30'd0, ST_GAP});
    u_if.rx_active = 1'b0;
    cyc();
    check("rx_gap_exit", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
    cyc();
    check("rx_regrant", {30'd0, u_if.dbg_state}, {30'd0, ST_PKT});
    send_beat(1'b0, 8'hC0, 1'b0);
    send_beat(1'b0, 8'hC1, 1'b0);
    send_beat(1'b0, 8'hC2, 1'b0);
    send_beat(1'b0, 8'hC3, 1'b1);
    wait_state(ST_IDLE, "rx_done");

    // stall timeout: reg granted with tx_tready low
    u_if.tx_tready = 1'b0;
    drive_reg(1'b1, 8'h84, 1'b0);
    wait_state(ST_REG, "to_grant");
    repeat (7) cyc();
    check("to_not_yet", {30'd0, u_if.dbg_state, 1'b0} | {31'd0, u_if.reg_abort}, {29'd0, ST_REG, 1'b0});
    cyc();
    check("to_abort", {30'd0, u_if.pkt_abort, u_if.reg_abort}, 32'd1);
    check("to_gap", {30'd0, u_if.dbg_state}, {30'd0, ST_GAP});
    drive_reg(1'b0, 8'h00, 1'b0);
    u_if.tx_tready = 1'b1;
    cyc();
    check("to_abort_1cyc", {31'd0, u_if.reg_abort}, 32'd0);
    wait_state(ST_IDLE, "to_idle");
    check("to_no_pkt_abort", n_pkt_ab, 1);

    // locking: pkt keeps the bus across a 3-cycle tvalid gap
    send_beat(1'b0, 8'hD0, 1'b0);
    drive_reg(1'b1, 8'hE0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_rdy", {31'd0, u_if.reg_tready}, 32'd0);
      cyc();
      check("lock_state", {30'd0, u_if.dbg_state}, {30'd0, ST_PKT});
    end
    send_beat(1'b0, 8'hD1, 1'b1);
    #1;
    check("lock_gap_rdy", {31'd0, u_if.reg_tready}, 32'd0);
    check("lock_gap", {30'd0, u_if.dbg_state}, {30'd0, ST_GAP});
    send_beat(1'b1, 8'hE0, 1'b1);
    wait_state(ST_IDLE, "lock_done");

    // async reset mid-packet, between clock edges
    send_beat(1'b0, 8'hF0, 1'b0);
    drive_pkt(1'b1, 8'hF1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", {28'd0, u_if.tx_tvalid, u_if.busy, u_if.pkt_tready, u_if.reg_tready}, 32'd0);
    check("arst_state", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
    drive_pkt(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    check("arst_pkt_ab", n_pkt_ab, 1);
    check("arst_reg_ab", n_reg_ab, 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
